// File: rtl/noc_demux_pipe_pkg.sv
// noc_pkg: shared NOC beat type, header field offsets and demux state encoding
package noc_pkg;
  typedef logic [143:0] NOCDataH;
  localparam int DEST_LSB = 0;
  localparam int LEN_LSB = 8;
  localparam logic [7:0] BCAST_ID = 8'hFF;
  typedef enum logic [1:0] {IDLE, LOCAL, FWD, BCAST} demux_state_t;
endpackage

// File: rtl/noc_demux_pipe_if.sv
// PipeIn/PipeOut: enq-style push stream and deq-style pull stream handshakes
interface PipeIn #(parameter int WIDTH = 144);
  logic enq__ENA;
  logic [WIDTH-1:0] enq_v;
  logic enq__RDY;
  modport server(input enq__ENA, enq_v, output enq__RDY);
  modport client(output enq__ENA, enq_v, input enq__RDY);
endinterface

interface PipeOut #(parameter int WIDTH = 144);
  logic deq__ENA;
  logic [WIDTH-1:0] deq_v;
  logic deq__RDY;
  modport server(input deq__ENA, output deq_v, deq__RDY);
  modport client(output deq__ENA, input deq_v, deq__RDY);
endinterface

// File: rtl/noc_demux_pipe_fifo.sv
// noc_fifo: power-of-two FIFO with registered full/empty flags
module noc_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 2
) (
  input logic CLK,
  input logic nRST,
  PipeIn.server in,
  PipeOut.server out
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic full, empty, doPush, doPop;
  assign doPop = out.deq__ENA && !empty;
  assign doPush = in.enq__ENA && (!full || doPop);
  assign in.enq__RDY = !full;
  assign out.deq__RDY = !empty;
  assign out.deq_v = mem[rdPtr];
  always_ff @(posedge CLK)
    if (doPush) mem[wrPtr] <= in.enq_v;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop) rdPtr <= rdPtr + AW'(1);
      if (doPush != doPop) begin
        full <= doPush && (wrPtr + AW'(1) == rdPtr);
        empty <= doPop && (rdPtr + AW'(1) == wrPtr);
      end
    end
endmodule

// File: rtl/noc_demux_pipe.sv
// noc_demux_pipe: routes packets by header dest to local out, forward FIFO, or both
module noc_demux_pipe
  import noc_pkg::*;
#(
  parameter int WIDTH = 144,
  parameter logic [7:0] MY_ID = 8'h00,
  parameter int FWD_DEPTH = 2
) (
  input logic CLK,
  input logic nRST,
  PipeIn.server in,
  PipeIn.client out,
  PipeIn.client forward
);
  demux_state_t state, route, hdrRoute;
  logic [7:0] remain, dest, len;
  logic inRdy, accept, fifoFull;
  PipeIn #(.WIDTH(WIDTH)) fifoIn();
  PipeOut #(.WIDTH(WIDTH)) fifoOut();
  noc_fifo #(.WIDTH(WIDTH), .DEPTH(FWD_DEPTH)) fwdFifo (
    .CLK(CLK),
    .nRST(nRST),
    .in(fifoIn),
    .out(fifoOut)
  );
  assign dest = in.enq_v[DEST_LSB +: 8];
  assign len = in.enq_v[LEN_LSB +: 8];
  assign fifoFull = !fifoIn.enq__RDY;
  always_comb begin
    hdrRoute = dest == MY_ID ? LOCAL : dest == BCAST_ID ? BCAST : FWD;
    route = state == IDLE ? hdrRoute : state;
    inRdy = nRST && (state == LOCAL ? out.enq__RDY :
                     state == FWD ? !fifoFull : out.enq__RDY && !fifoFull);
    accept = in.enq__ENA && inRdy;
  end
  assign in.enq__RDY = inRdy;
  assign out.enq__ENA = accept && route != FWD;
  assign out.enq_v = out.enq__ENA ? in.enq_v : '0;
  assign fifoIn.enq__ENA = accept && route != LOCAL;
  assign fifoIn.enq_v = in.enq_v;
  assign forward.enq__ENA = nRST && fifoOut.deq__RDY;
  assign forward.enq_v = fifoOut.deq_v;
  assign fifoOut.deq__ENA = forward.enq__ENA && forward.enq__RDY;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      remain <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        remain <= len;
        state <= len == 8'd0 ? IDLE : hdrRoute;
      end else begin
        remain <= remain - 8'd1;
        if (remain == 8'd1) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_noc_demux_pipe.sv
// tb_noc_demux_pipe: directed checks of routing, backpressure, broadcast, reset and LEN=255
module tb_noc_demux_pipe;
  import noc_pkg::*;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int checks = 0;
  int errors = 0;
  int n;
  NOCDataH h;
  always #5 CLK = ~CLK;
  PipeIn #(.WIDTH(144)) inIf();
  PipeIn #(.WIDTH(144)) outIf();
  PipeIn #(.WIDTH(144)) fwdIf();
  noc_demux_pipe #(.WIDTH(144), .MY_ID(8'h03), .FWD_DEPTH(2)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .in(inIf),
    .out(outIf),
    .forward(fwdIf)
  );
  task automatic check(string tag, logic [143:0] got, logic [143:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic NOCDataH beat(logic [7:0] dest, logic [7:0] len, logic [127:0] tag);
    return {tag, len, dest};
  endfunction
  task automatic drive(logic ena, NOCDataH d);
    @(negedge CLK);
    inIf.enq__ENA = ena;
    inIf.enq_v = d;
    #1;
  endtask
  initial begin
    inIf.enq__ENA = 1'b0;
    inIf.enq_v = '0;
    outIf.enq__RDY = 1'b1;
    fwdIf.enq__RDY = 1'b0;
    #2;
    check("rst inRdy", inIf.enq__RDY, 0);
    check("rst outEna", outIf.enq__ENA, 0);
    check("rst fwdEna", fwdIf.enq__ENA, 0);
    check("rst outData", outIf.enq_v, 0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1, beat(8'h03, 8'd0, 128'hA0));
    check("loc ena", outIf.enq__ENA, 1);
    check("loc data", outIf.enq_v, beat(8'h03, 8'd0, 128'hA0));
    check("loc fwdEna", fwdIf.enq__ENA, 0);
    check("loc inRdy", inIf.enq__RDY, 1);
    drive(0, '0);
    check("loc idle ena", outIf.enq__ENA, 0);
    check("loc idle data", outIf.enq_v, 0);
    check("loc fwd after", fwdIf.enq__ENA, 0);
    fwdIf.enq__RDY = 1'b1;
    drive(1, beat(8'h07, 8'd2, 128'hB0));
    check("fwd hdr out", outIf.enq__ENA, 0);
    check("fwd hdr fwdEna", fwdIf.enq__ENA, 0);
    drive(1, beat(8'h03, 8'd0, 128'hB1));
    check("fwd b0 ena", fwdIf.enq__ENA, 1);
    check("fwd b0 data", fwdIf.enq_v, beat(8'h07, 8'd2, 128'hB0));
    check("fwd b1 out", outIf.enq__ENA, 0);
    drive(1, beat(8'h03, 8'd0, 128'hB2));
    check("fwd b1 data", fwdIf.enq_v, beat(8'h03, 8'd0, 128'hB1));
    check("fwd b2 out", outIf.enq__ENA, 0);
    drive(0, '0);
    check("fwd b2 ena", fwdIf.enq__ENA, 1);
    check("fwd b2 data", fwdIf.enq_v, beat(8'h03, 8'd0, 128'hB2));
    drive(0, '0);
    check("fwd drained", fwdIf.enq__ENA, 0);
    fwdIf.enq__RDY = 1'b0;
    drive(1, beat(8'h07, 8'd1, 128'hC0));
    drive(1, beat(8'h03, 8'd0, 128'hC1));
    drive(1, beat(8'h07, 8'd0, 128'hC2));
    check("bp full inRdy", inIf.enq__RDY, 0);
    check("bp head c0", fwdIf.enq_v, beat(8'h07, 8'd1, 128'hC0));
    @(negedge CLK);
    fwdIf.enq__RDY = 1'b1;
    #1;
    check("bp release inRdy", inIf.enq__RDY, 0);
    check("bp release head", fwdIf.enq_v, beat(8'h07, 8'd1, 128'hC0));
    @(negedge CLK);
    #1;
    check("bp after pop inRdy", inIf.enq__RDY, 1);
    check("bp head c1", fwdIf.enq_v, beat(8'h03, 8'd0, 128'hC1));
    drive(0, '0);
    check("bp c2 ena", fwdIf.enq__ENA, 1);
    check("bp head c2", fwdIf.enq_v, beat(8'h07, 8'd0, 128'hC2));
    drive(0, '0);
    check("bp drained", fwdIf.enq__ENA, 0);
    outIf.enq__RDY = 1'b0;
    drive(1, beat(8'hFF, 8'd1, 128'hD0));
    repeat (3) begin
      check("bc stall inRdy", inIf.enq__RDY, 0);
      check("bc stall out", outIf.enq__ENA, 0);
      check("bc stall fwd", fwdIf.enq__ENA, 0);
      @(negedge CLK);
    end
    outIf.enq__RDY = 1'b1;
    #1;
    check("bc hdr inRdy", inIf.enq__RDY, 1);
    check("bc hdr out", outIf.enq_v, beat(8'hFF, 8'd1, 128'hD0));
    drive(1, beat(8'h07, 8'd0, 128'hD1));
    check("bc pay outEna", outIf.enq__ENA, 1);
    check("bc pay out", outIf.enq_v, beat(8'h07, 8'd0, 128'hD1));
    check("bc hdr fwd", fwdIf.enq_v, beat(8'hFF, 8'd1, 128'hD0));
    drive(0, '0);
    check("bc pay fwd", fwdIf.enq_v, beat(8'h07, 8'd0, 128'hD1));
    check("bc end out", outIf.enq__ENA, 0);
    drive(0, '0);
    check("bc drained", fwdIf.enq__ENA, 0);
    fwdIf.enq__RDY = 1'b0;
    drive(1, beat(8'h07, 8'd0, 128'hE9));
    drive(1, beat(8'h03, 8'd4, 128'hE0));
    check("rm hdr out", outIf.enq__ENA, 1);
    drive(1, beat(8'h07, 8'd0, 128'hE1));
    check("rm pay out", outIf.enq__ENA, 1);
    drive(1, beat(8'h07, 8'd0, 128'hE2));
    check("rm parked fwd", fwdIf.enq__ENA, 1);
    #2;
    nRST = 1'b0;
    #1;
    check("rm async out", outIf.enq__ENA, 0);
    check("rm async fwd", fwdIf.enq__ENA, 0);
    check("rm async inRdy", inIf.enq__RDY, 0);
    @(negedge CLK);
    nRST = 1'b1;
    fwdIf.enq__RDY = 1'b1;
    inIf.enq_v = beat(8'h07, 8'd0, 128'hF0);
    #1;
    check("rm hdr out", outIf.enq__ENA, 0);
    check("rm hdr inRdy", inIf.enq__RDY, 1);
    drive(0, '0);
    check("rm fwd ena", fwdIf.enq__ENA, 1);
    check("rm fwd data", fwdIf.enq_v, beat(8'h07, 8'd0, 128'hF0));
    drive(0, '0);
    check("rm drained", fwdIf.enq__ENA, 0);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      h = i == 0 ? beat(8'h03, 8'd255, 128'hAA) : beat(8'h07, 8'(i), 128'(i));
      drive(1, h);
      if (outIf.enq__ENA && outIf.enq_v == h && !fwdIf.enq__ENA) n++;
    end
    check("len255 beats", n, 256);
    drive(1, beat(8'h07, 8'd0, 128'hBB));
    check("b2b out", outIf.enq__ENA, 0);
    check("b2b inRdy", inIf.enq__RDY, 1);
    drive(0, '0);
    check("b2b fwd ena", fwdIf.enq__ENA, 1);
    check("b2b fwd data", fwdIf.enq_v, beat(8'h07, 8'd0, 128'hBB));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_demux_pipe.md
# noc_demux_pipe

Splits one incoming NOCDataH packet stream into a local output and a forward output, routing each packet by the destination id in its header beat. It is the egress-side counterpart of the two-into-one merge stage in the NOC pipeline. Local packets pass combinationally to `out`. Forwarded packets are buffered in a small FIFO before `forward`. Broadcast packets are copied to both outputs.

## Interface
- `WIDTH`, default 144: beat width; matches NOCDataH.
- `MY_ID`, default 8'h00: node id; packets with this destination route to `out`.
- `FWD_DEPTH`, default 2: entries in the forward FIFO; power of two, ≥ 2.
- `CLK`, input, 1: single clock; all state on rising edge.
- `nRST`, input, 1: asynchronous, active-low reset.
- `in`, PipeIn.server, WIDTH: inbound stream; signals `enq__ENA`, `enq$v`, `enq__RDY`.
- `out`, PipeIn.client, WIDTH: local-destination stream.
- `forward`, PipeIn.client, WIDTH: pass-through stream, driven from the forward FIFO head.

## Operation
- **Header beat fields:**
  - `[7:0]` destination id.
  - `[15:8]` LEN: payload beats following the header, 0–255.
  - Remaining bits are opaque.
- **Header routing:**
  - Destination == `MY_ID` routes the packet to LOCAL.
  - Destination == 8'hFF routes the packet to BCAST.
  - Any other destination routes the packet to FWD.
- **States:** IDLE, LOCAL, FWD, BCAST; plus an 8-bit `remain` counter.
- **IDLE (expecting header):**
  - `in.enq__RDY` = `out.enq__RDY` && FIFO not full.
  - `in.enq__RDY` never depends on `in.enq$v`.
  - On header accept, the header goes to its route: `out`, FIFO push, or both.
  - `remain` loads LEN.
  - If LEN == 0, the FSM stays in IDLE; otherwise it moves to the route state.
- **LOCAL:**
  - `in.enq__RDY` = `out.enq__RDY`.
  - The beat is copied to `out.enq$v` with `out.enq__ENA` = `in.enq__ENA`.
- **FWD:**
  - `in.enq__RDY` = FIFO not full.
  - An accepted beat is pushed into the FIFO.
- **BCAST:**
  - `in.enq__RDY` = `out.enq__RDY` && FIFO not full.
  - The beat is delivered to both paths in the same cycle.
- **Payload accounting:** each accepted payload beat decrements `remain`. Accepting the beat with `remain` == 1 returns the FSM to IDLE.
- **Output idle values:** when not enabled, `out.enq$v` = 0 and `out.enq__ENA` = 0.
- **Forward output:**
  - `forward.enq__ENA` = FIFO not empty.
  - `forward.enq$v` = FIFO head.
  - The head is popped when `forward.enq__ENA` && `forward.enq__RDY`.
- **FIFO push/pop:** a push and a pop in the same cycle are both honoured, including when the FIFO is full. The full flag used for `in.enq__RDY` is the registered full flag and does not account for a same-cycle pop.

## Timing
- **Reset:**
  - State IDLE, `remain` 0, FIFO empty.
  - `out.enq__ENA` = 0, `forward.enq__ENA` = 0, `in.enq__RDY` = 0 while `nRST` is low.
- **Reset mid-packet:** the partial packet is dropped and FIFO contents are discarded. The next accepted beat after reset is treated as a header.
- **Latency:**
  - `in` to `out`: 0 cycles (combinational).
  - `in` to `forward`: 1 cycle minimum (FIFO write, then visible next cycle).
- **Throughput:**
  - 1 beat/cycle on each path when the downstream is ready.
  - Sustained forward traffic at 1 beat/cycle requires FIFO not full.
- **Stalls:** a local stall (`out.enq__RDY` = 0) blocks `in` in IDLE, LOCAL and BCAST. A FIFO-full condition blocks `in` in IDLE, FWD and BCAST.
- **Ordering:** beats within a packet keep their order. Packets keep their order per output; no ordering is guaranteed across outputs.
- **Back-to-back:** a header may be accepted in the cycle immediately after the last payload beat of the previous packet.
- **Counter:** LEN = 255 produces 256 beats total. `remain` never wraps; the 0 → IDLE transition happens on the last payload beat.

## Structure
- **Shared package `noc_pkg`:**
  - NOCDataH typedef, 144 bits.
  - Field offsets `DEST_LSB` = 0 and `LEN_LSB` = 8.
  - `BCAST_ID` = 8'hFF.
  - State enum `demux_state_t`.
- **Sub-module `noc_fifo`:** WIDTH/DEPTH parameters, PipeIn in / PipeOut out, asynchronous active-low reset, registered full/empty flags. It is instantiated once for the forward path.
- **Top level:** the FSM, the `remain` counter and the output steering.

## Test plan
- **Local single beat:** MY_ID = 3; header dest 3, LEN 0; `out.enq__RDY` = 1 → same-cycle `out.enq__ENA` = 1 with matching data; `forward.enq__ENA` stays 0.
- **Forward packet:** header dest 7, LEN 2, then 2 payload beats; `forward.enq__RDY` = 1 → 3 beats on `forward` in order, first one cycle after acceptance; `out` silent.
- **Backpressure:** FIFO full and `forward.enq__RDY` = 0 → `in.enq__RDY` = 0. Release `forward.enq__RDY` → one pop per cycle, and `in.enq__RDY` rises the cycle after the first pop.
- **Broadcast:** dest FF, LEN 1; `out.enq__RDY` held 0 for 3 cycles → no beat accepted. When released, each beat appears on both `out` and `forward`.
- **Reset mid-packet:** assert `nRST` after 1 of 4 payload beats of a LOCAL packet → all ENA outputs 0 asynchronously. After release, the next beat (dest 7) is routed as a header to `forward`.
- **LEN = 255 then back-to-back:** LEN 255 local packet → exactly 256 beats on `out`. The next header in the following cycle is accepted and routed by its own dest.
